register_read_port: RTL and testbench

REGISTER_READ_PORT -- requirements
Module: register_read_port

---
 rtl/register_read_port.sv | 107 ++++++++++
 tb/tb_register_read_port.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/register_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : register_read_port                                                |
// | Desc   : Two-port registered read of a 16-entry register bank with         |
// |          write bypass, one-deep valid/ready response buffer and counter.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module register_read_port #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  R0,
   input  logic [DATA_WIDTH-1:0]  R1,
   input  logic [DATA_WIDTH-1:0]  R2,
   input  logic [DATA_WIDTH-1:0]  R3,
   input  logic [DATA_WIDTH-1:0]  R4,
   input  logic [DATA_WIDTH-1:0]  R5,
   input  logic [DATA_WIDTH-1:0]  R6,
   input  logic [DATA_WIDTH-1:0]  R7,
   input  logic [DATA_WIDTH-1:0]  R8,
   input  logic [DATA_WIDTH-1:0]  R9,
   input  logic [DATA_WIDTH-1:0]  R10,
   input  logic [DATA_WIDTH-1:0]  R11,
   input  logic [DATA_WIDTH-1:0]  R12,
   input  logic [DATA_WIDTH-1:0]  R13,
   input  logic [DATA_WIDTH-1:0]  R14,
   input  logic [DATA_WIDTH-1:0]  R15,
   input  logic [15:0]            enable,
   input  logic [DATA_WIDTH-1:0]  load_data,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             addr_a,
   input  logic [3:0]             addr_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  data_a,
   output logic [DATA_WIDTH-1:0]  data_b,
   output logic [COUNT_WIDTH-1:0] read_count
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 r_state;
   logic [DATA_WIDTH-1:0]  r_data_a;
   logic [DATA_WIDTH-1:0]  r_data_b;
   logic [COUNT_WIDTH-1:0] r_read_count;

   logic [DATA_WIDTH-1:0]  w_bank [16];
   logic [DATA_WIDTH-1:0]  w_sel_a;
   logic [DATA_WIDTH-1:0]  w_sel_b;
   logic                   w_accept;

   assign w_bank[0]  = R0;
   assign w_bank[1]  = R1;
   assign w_bank[2]  = R2;
   assign w_bank[3]  = R3;
   assign w_bank[4]  = R4;
   assign w_bank[5]  = R5;
   assign w_bank[6]  = R6;
   assign w_bank[7]  = R7;
   assign w_bank[8]  = R8;
   assign w_bank[9]  = R9;
   assign w_bank[10] = R10;
   assign w_bank[11] = R11;
   assign w_bank[12] = R12;
   assign w_bank[13] = R13;
   assign w_bank[14] = R14;
   assign w_bank[15] = R15;

   // A write landing in the same cycle wins, so the response sees the new value.
   always_comb begin
      w_sel_a = enable[addr_a] ? load_data : w_bank[addr_a];
      w_sel_b = enable[addr_b] ? load_data : w_bank[addr_b];
   end

   assign req_ready  = (r_state == ST_EMPTY) | rsp_ready;
   assign w_accept   = req_valid & req_ready;
   assign rsp_valid  = (r_state == ST_FULL);
   assign data_a     = r_data_a;
   assign data_b     = r_data_b;
   assign read_count = r_read_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_EMPTY;
         r_data_a     <= '0;
         r_data_b     <= '0;
         r_read_count <= '0;
      end else if (w_accept) begin
         r_state      <= ST_FULL;
         r_data_a     <= w_sel_a;
         r_data_b     <= w_sel_b;
         r_read_count <= r_read_count + c_count_one;
      end else if ((r_state == ST_FULL) && rsp_ready) begin
         r_state      <= ST_EMPTY;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_register_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_register_read_port                                             |
// | Desc   : Randomized and directed self-checking bench for register_read_port|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_register_read_port;

   localparam int DATA_WIDTH  = 32;
   localparam int COUNT_WIDTH = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [DATA_WIDTH-1:0]  bank [16];
   logic [15:0]            enable;
   logic [DATA_WIDTH-1:0]  load_data;
   logic                   req_valid;
   logic                   req_ready;
   logic [3:0]             addr_a;
   logic [3:0]             addr_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_WIDTH-1:0]  data_a;
   logic [DATA_WIDTH-1:0]  data_b;
   logic [COUNT_WIDTH-1:0] read_count;

   int errors = 0;
   int checks = 0;

   // Reference: one optional pending response plus an accept counter.
   bit                    m_valid;
   bit                    m_known;
   logic [DATA_WIDTH-1:0] m_a;
   logic [DATA_WIDTH-1:0] m_b;
   int                    m_count;

   always #5 clk = ~clk;

   register_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .R0        (bank[0]),
      .R1        (bank[1]),
      .R2        (bank[2]),
      .R3        (bank[3]),
      .R4        (bank[4]),
      .R5        (bank[5]),
      .R6        (bank[6]),
      .R7        (bank[7]),
      .R8        (bank[8]),
      .R9        (bank[9]),
      .R10       (bank[10]),
      .R11       (bank[11]),
      .R12       (bank[12]),
      .R13       (bank[13]),
      .R14       (bank[14]),
      .R15       (bank[15]),
      .enable    (enable),
      .load_data (load_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .data_a    (data_a),
      .data_b    (data_b),
      .read_count(read_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock: inputs are already driven; the bank behaves as a register file.
   task automatic tick();
      logic [DATA_WIDTH-1:0] nb [16];
      bit exp_ready, acc, con;
      #1;
      exp_ready = !m_valid || rsp_ready;
      check("req_ready", req_ready, exp_ready);
      acc = req_valid && exp_ready;
      con = m_valid && rsp_ready;
      nb  = bank;
      for (int i = 0; i < 16; i++)
         if (enable[i]) nb[i] = load_data;
      @(posedge clk);
      #1;
      if (reset) begin
         m_valid = 0; m_known = 1; m_a = '0; m_b = '0; m_count = 0;
      end else if (acc) begin
         // Captured value equals what the register holds after this cycle's write.
         m_valid = 1; m_known = 1; m_a = nb[addr_a]; m_b = nb[addr_b];
         m_count = (m_count + 1) % (1 << COUNT_WIDTH);
      end else if (con) begin
         m_valid = 0; m_known = 0;
      end
      bank = nb;
      check("rsp_valid", rsp_valid, m_valid);
      check("read_count", read_count, 64'(m_count));
      if (m_known) begin
         check("data_a", data_a, m_a);
         check("data_b", data_b, m_b);
      end
   endtask

   task automatic idle();
      req_valid = 0; enable = '0; rsp_ready = 1; reset = 0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) bank[i] = $urandom;
      bank[0] = 7; bank[2] = 5; bank[3] = 8196;
      m_valid = 0; m_known = 0; m_a = '0; m_b = '0; m_count = 0;
      enable = '0; load_data = '0; req_valid = 0; rsp_ready = 0;
      addr_a = '0; addr_b = '0; reset = 1;
      tick();
      tick();
      check("reset_data_a", data_a, 0);
      idle();

      // Plain read
      req_valid = 1; addr_a = 3; addr_b = 0;
      tick();
      check("plain_data_a", data_a, 8196);
      check("plain_data_b", data_b, 7);
      check("plain_count", read_count, 1);

      // Single-hot bypass, same address on both ports
      enable = 16'd4; load_data = 24974; addr_a = 2; addr_b = 2;
      tick();
      check("bypass_a", data_a, 24974);
      check("bypass_b", data_b, 24974);

      // Multi-hot bypass
      enable = 16'd54; load_data = 16; addr_a = 1; addr_b = 3;
      tick();
      check("multihot_a", data_a, 16);
      check("multihot_b", data_b, 8196);

      // Backpressure while the held source register keeps changing
      rsp_ready = 0; req_valid = 1; addr_a = 7; addr_b = 9;
      for (int k = 0; k < 3; k++) begin
         enable = 16'h0002; load_data = $urandom;
         tick();
         check("held_a", data_a, 16);
         check("held_count", read_count, 3);
      end
      enable = '0; rsp_ready = 1;
      tick();
      check("released_count", read_count, 4);
      idle();
      tick();

      // Back-to-back from reset
      reset = 1; tick(); reset = 0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; rsp_ready = 1; addr_a = 4'(i); addr_b = 4'(4 - i);
         tick();
      end
      idle();
      check("b2b_count", read_count, 5);
      tick();

      // Reset with an unconsumed response and a concurrent request
      bank[6] = 5; req_valid = 1; addr_a = 6; addr_b = 6;
      tick();
      req_valid = 0; rsp_ready = 0;
      tick();
      check("pre_reset_a", data_a, 5);
      reset = 1; req_valid = 1;
      tick();
      reset = 0; req_valid = 0;
      check("mid_reset_valid", rsp_valid, 0);
      check("mid_reset_a", data_a, 0);
      check("mid_reset_count", read_count, 0);
      tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 59) == 0);
         req_valid = $urandom_range(0, 3) != 0;
         rsp_ready = $urandom_range(0, 2) != 0;
         addr_a    = 4'($urandom);
         addr_b    = ($urandom_range(0, 4) == 0) ? addr_a : 4'($urandom);
         enable    = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
         load_data = $urandom;
         tick();
      end

      // Counter wrap
      idle(); reset = 1; tick(); reset = 0;
      req_valid = 1; rsp_ready = 1;
      for (int n = 0; n < 65535; n++) begin
         addr_a = 4'(n); addr_b = 4'(n >> 4);
         tick();
      end
      check("pre_wrap_count", read_count, 65535);
      tick();
      check("wrap_count", read_count, 0);
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
